spi_master_engine: RTL

- Single-word SPI master. Accepts a parallel word over a valid/ready handshake and drives chip_select, serial_clock and serial_out in any of the four CPOL/CPHA modes.
- Shifts serial_in back and returns the received word with a one-cycle valid pulse.
- It is the initiator counterpart of the SPI slave simulation model: the bench connects the two back-to-back, and RTL users place it between register logic and the external SPI pins.

---
 rtl/spi_master_engine.sv | 130 +++++++++++++
 1 files changed

// File: rtl/spi_master_engine.sv
// Single-word SPI master: takes a parallel word over valid/ready and runs one
// chip-select framed transfer in any CPOL/CPHA mode, returning the received word.
module spi_master_engine #(
   parameter int DATA_WIDTH    = 32,
   parameter int DIVIDER_WIDTH = 16
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     clock_polarity,
   input  logic                     clock_phase,
   input  logic [DIVIDER_WIDTH-1:0] divider,
   input  logic [DATA_WIDTH-1:0]    transmit_data,
   input  logic                     transmit_valid,
   output logic                     transmit_ready,
   output logic [DATA_WIDTH-1:0]    receive_data,
   output logic                     receive_valid,
   output logic                     busy,
   output logic                     chip_select,
   output logic                     serial_clock,
   output logic                     serial_out,
   input  logic                     serial_in
);

   localparam int EDGE_WIDTH = $clog2(2 * DATA_WIDTH) + 1;
   localparam logic [EDGE_WIDTH-1:0] LAST_EDGE = EDGE_WIDTH'(2 * DATA_WIDTH);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

   state_t                   state;
   state_t                   state_next;
   logic                     cpha_q;
   logic [DIVIDER_WIDTH-1:0] half_period_q;
   logic [DIVIDER_WIDTH-1:0] div_count;
   logic [EDGE_WIDTH-1:0]    edge_count;
   logic [DATA_WIDTH-1:0]    tx_shift;
   logic [DATA_WIDTH-1:0]    rx_shift;

   logic                     accept;
   logic                     tick;
   logic                     shift_tick;
   logic                     sample_edge;
   logic                     launch_edge;
   logic [EDGE_WIDTH-1:0]    edge_next;
   logic [DIVIDER_WIDTH-1:0] divider_eff;

   // Every tick is one scheduled event: a serial_clock edge while framing, the CS rise in HOLD
   always_comb begin
      divider_eff = (divider == '0) ? DIVIDER_WIDTH'(1) : divider;
      accept      = (state == IDLE) && transmit_valid && transmit_ready;
      tick        = (state != IDLE) && (div_count == '0);
      shift_tick  = tick && ((state == SETUP) || (state == SHIFT));
      edge_next   = edge_count + EDGE_WIDTH'(1);
      sample_edge = shift_tick && (edge_next[0] ^ cpha_q);
      launch_edge = shift_tick && !(edge_next[0] ^ cpha_q) && (edge_next != LAST_EDGE);
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = SETUP;
         SETUP:   if (tick) state_next = SHIFT;
         SHIFT:   if (tick && (edge_next == LAST_EDGE)) state_next = HOLD;
         HOLD:    if (tick) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         transmit_ready <= 1'b0;
         receive_data   <= '0;
         receive_valid  <= 1'b0;
         busy           <= 1'b0;
         chip_select    <= 1'b1;
         serial_clock   <= 1'b0;
         serial_out     <= 1'b0;
         cpha_q         <= 1'b0;
         half_period_q  <= '0;
         div_count      <= '0;
         edge_count     <= '0;
         tx_shift       <= '0;
         rx_shift       <= '0;
      end else begin
         receive_valid <= 1'b0;
         if (state == IDLE) begin
            transmit_ready <= !accept;
            busy           <= accept;
            serial_clock   <= clock_polarity;
            if (accept) begin
               cpha_q        <= clock_phase;
               half_period_q <= divider_eff;
               div_count     <= divider_eff - DIVIDER_WIDTH'(1);
               edge_count    <= '0;
               chip_select   <= 1'b0;
               rx_shift      <= '0;
               // CPHA=0 must present the MSB before the first (sampling) edge
               if (!clock_phase) begin
                  serial_out <= transmit_data[DATA_WIDTH-1];
                  tx_shift   <= transmit_data << 1;
               end else begin
                  tx_shift   <= transmit_data;
               end
            end
         end else begin
            div_count <= tick ? (half_period_q - DIVIDER_WIDTH'(1))
                              : (div_count - DIVIDER_WIDTH'(1));
            if (shift_tick) begin
               serial_clock <= ~serial_clock;
               edge_count   <= edge_next;
            end
            if (sample_edge) rx_shift <= {rx_shift[DATA_WIDTH-2:0], serial_in};
            if (launch_edge) begin
               serial_out <= tx_shift[DATA_WIDTH-1];
               tx_shift   <= tx_shift << 1;
            end
            if (tick && (state == HOLD)) begin
               chip_select   <= 1'b1;
               receive_data  <= rx_shift;
               receive_valid <= 1'b1;
            end
         end
      end
   end

endmodule
